// File: rtl/paint_canvas_scheduler.sv
// Turns cursor position and button levels into whole-cell paints (one cell-memory
// write, then a SCALE x SCALE pixel raster) and runs full-canvas clears on the same port.
module paint_canvas_scheduler #(
  parameter logic [8:0] CX0   = 9'd16,
  parameter logic [8:0] CY0   = 9'd4,
  parameter int         CELLS = 28,
  parameter int         SHIFT = 2,
  parameter logic [2:0] INK   = 3'b111,
  parameter logic [2:0] BG    = 3'b000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [8:0] x_pos,
  input  logic [8:0] y_pos,
  input  logic       left_click,
  input  logic       right_click,
  input  logic       clear_req,
  output logic [8:0] vga_x,
  output logic [8:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic [9:0] cell_addr,
  output logic       cell_data,
  output logic       cell_wr,
  output logic       enable_tracking,
  output logic       busy,
  output logic       clear_done
);

  localparam int               CW     = $clog2(CELLS);
  localparam int               SPAN   = CELLS << SHIFT;
  localparam logic [9:0]       X_END  = 10'({1'b0, CX0}) + 10'(SPAN);
  localparam logic [9:0]       Y_END  = 10'({1'b0, CY0}) + 10'(SPAN);
  localparam logic [CW-1:0]    LAST_C = CW'(CELLS - 1);
  localparam logic [SHIFT-1:0] PMAX   = '1;

  typedef enum logic [1:0] {IDLE, CELL, BLOCK, NEXT} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cx_q, cx_d, cy_q, cy_d;
  logic [CW-1:0]    last_cx_q, last_cx_d, last_cy_q, last_cy_d;
  logic [SHIFT-1:0] px_q, px_d, py_q, py_d;
  logic             ink_q, ink_d, last_ink_q, last_ink_d;
  logic             clearing_q, clearing_d;
  logic             pend_q, pend_d;
  logic             last_valid_q, last_valid_d;

  logic [8:0] vga_x_d, vga_y_d;
  logic [2:0] colour_d;
  logic [9:0] addr_d;
  logic       plot_d, data_d, wr_d, track_d, done_d;

  logic          in_canvas, click, mink, same_last;
  logic [CW-1:0] mcx, mcy;

  function automatic logic [9:0] addr_of(input logic [CW-1:0] cxv, input logic [CW-1:0] cyv);
    addr_of = 10'(int'(cyv) * CELLS + int'(cxv));
  endfunction

  function automatic logic [8:0] pix(input logic [8:0] org, input logic [CW-1:0] c,
                                     input logic [SHIFT-1:0] p);
    pix = org + (9'(c) << SHIFT) + 9'(p);
  endfunction

  assign in_canvas = ({1'b0, x_pos} >= {1'b0, CX0}) && ({1'b0, x_pos} < X_END) &&
                     ({1'b0, y_pos} >= {1'b0, CY0}) && ({1'b0, y_pos} < Y_END);
  assign mcx       = CW'((x_pos - CX0) >> SHIFT);
  assign mcy       = CW'((y_pos - CY0) >> SHIFT);
  assign click     = left_click | right_click;
  assign mink      = left_click;
  // Re-painting the cell just painted with the same ink would only waste port cycles.
  assign same_last = last_valid_q && (mcx == last_cx_q) && (mcy == last_cy_q) &&
                     (mink == last_ink_q);
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    px_d         = px_q;
    py_d         = py_q;
    ink_d        = ink_q;
    clearing_d   = clearing_q;
    pend_d       = pend_q | clear_req;
    last_valid_d = last_valid_q;
    last_cx_d    = last_cx_q;
    last_cy_d    = last_cy_q;
    last_ink_d   = last_ink_q;
    vga_x_d      = vga_x;
    vga_y_d      = vga_y;
    colour_d     = vga_colour;
    addr_d       = cell_addr;
    data_d       = cell_data;
    track_d      = enable_tracking;
    plot_d       = 1'b0;
    wr_d         = 1'b0;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (pend_q) begin
          state_d    = CELL;
          pend_d     = 1'b0;
          clearing_d = 1'b1;
          cx_d       = '0;
          cy_d       = '0;
          ink_d      = 1'b0;
          track_d    = 1'b0;
          wr_d       = 1'b1;
          addr_d     = '0;
          data_d     = 1'b0;
          colour_d   = BG;
        end else if (in_canvas && click && !same_last) begin
          state_d    = CELL;
          clearing_d = 1'b0;
          cx_d       = mcx;
          cy_d       = mcy;
          ink_d      = mink;
          wr_d       = 1'b1;
          addr_d     = addr_of(mcx, mcy);
          data_d     = mink;
          colour_d   = mink ? INK : BG;
        end
      end
      CELL: begin
        state_d  = BLOCK;
        px_d     = '0;
        py_d     = '0;
        plot_d   = 1'b1;
        vga_x_d  = pix(CX0, cx_q, '0);
        vga_y_d  = pix(CY0, cy_q, '0);
        colour_d = ink_q ? INK : BG;
      end
      BLOCK: begin
        if (px_q == PMAX && py_q == PMAX) begin
          if (clearing_q) begin
            state_d = NEXT;
          end else begin
            state_d      = IDLE;
            last_valid_d = 1'b1;
            last_cx_d    = cx_q;
            last_cy_d    = cy_q;
            last_ink_d   = ink_q;
          end
        end else begin
          px_d = px_q + 1'b1;
          if (px_q == PMAX) py_d = py_q + 1'b1;
          plot_d  = 1'b1;
          vga_x_d = pix(CX0, cx_q, px_d);
          vga_y_d = pix(CY0, cy_q, py_d);
        end
      end
      NEXT: begin
        if (cx_q == LAST_C && cy_q == LAST_C) begin
          state_d      = IDLE;
          clearing_d   = 1'b0;
          done_d       = 1'b1;
          track_d      = 1'b1;
          last_valid_d = 1'b0;
        end else begin
          if (cx_q == LAST_C) begin
            cx_d = '0;
            cy_d = cy_q + 1'b1;
          end else begin
            cx_d = cx_q + 1'b1;
          end
          state_d = CELL;
          wr_d    = 1'b1;
          addr_d  = addr_of(cx_d, cy_d);
          data_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      cx_q            <= '0;
      cy_q            <= '0;
      px_q            <= '0;
      py_q            <= '0;
      ink_q           <= 1'b0;
      clearing_q      <= 1'b0;
      pend_q          <= 1'b0;
      last_valid_q    <= 1'b0;
      last_cx_q       <= '0;
      last_cy_q       <= '0;
      last_ink_q      <= 1'b0;
      vga_x           <= '0;
      vga_y           <= '0;
      vga_colour      <= '0;
      vga_plot        <= 1'b0;
      cell_addr       <= '0;
      cell_data       <= 1'b0;
      cell_wr         <= 1'b0;
      enable_tracking <= 1'b1;
      clear_done      <= 1'b0;
    end else begin
      state_q         <= state_d;
      cx_q            <= cx_d;
      cy_q            <= cy_d;
      px_q            <= px_d;
      py_q            <= py_d;
      ink_q           <= ink_d;
      clearing_q      <= clearing_d;
      pend_q          <= pend_d;
      last_valid_q    <= last_valid_d;
      last_cx_q       <= last_cx_d;
      last_cy_q       <= last_cy_d;
      last_ink_q      <= last_ink_d;
      vga_x           <= vga_x_d;
      vga_y           <= vga_y_d;
      vga_colour      <= colour_d;
      vga_plot        <= plot_d;
      cell_addr       <= addr_d;
      cell_data       <= data_d;
      cell_wr         <= wr_d;
      enable_tracking <= track_d;
      clear_done      <= done_d;
    end
  end

endmodule

// File: tb/tb_paint_canvas_scheduler.sv
// Directed bench for paint_canvas_scheduler: paint raster, repeat suppression,
// button priority, canvas bounds, full clear and reset during a clear.
module tb_paint_canvas_scheduler;

  logic       clock, reset;
  logic [8:0] x_pos, y_pos;
  logic       left_click, right_click, clear_req;
  logic [8:0] vga_x, vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic [9:0] cell_addr;
  logic       cell_data, cell_wr, enable_tracking, busy, clear_done;

  int vectors = 0;
  int miscompares = 0;

  int         wr_cnt, plot_cnt, nonbg_cnt, both_cnt, done_cnt, data1_cnt;
  logic [9:0] last_addr;
  logic       last_data;
  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];

  paint_canvas_scheduler dut (
    .clock(clock), .reset(reset), .x_pos(x_pos), .y_pos(y_pos),
    .left_click(left_click), .right_click(right_click), .clear_req(clear_req),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .cell_addr(cell_addr), .cell_data(cell_data), .cell_wr(cell_wr),
    .enable_tracking(enable_tracking), .busy(busy), .clear_done(clear_done)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Event recorder feeding the per-test comparisons
  always @(negedge clock) begin
    if (!reset) begin
      if (cell_wr) begin
        wr_cnt++;
        got_q.push_back(cell_addr);
        last_addr = cell_addr;
        last_data = cell_data;
        if (cell_data) data1_cnt++;
      end
      if (vga_plot) begin
        plot_cnt++;
        if (vga_colour != 3'b000) nonbg_cnt++;
      end
      if (vga_plot && cell_wr) both_cnt++;
      if (clear_done) done_cnt++;
    end
  end

  task automatic clr_mon();
    wr_cnt = 0; plot_cnt = 0; nonbg_cnt = 0; both_cnt = 0; done_cnt = 0; data1_cnt = 0;
    last_addr = '0; last_data = 1'b0;
    got_q.delete();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; x_pos = '0; y_pos = '0;
    left_click = 1'b0; right_click = 1'b0; clear_req = 1'b0;
    wait_cycles(2);
    vectors++;
    if ({vga_plot, cell_wr, busy, clear_done, enable_tracking} !== 5'b00001) begin
      miscompares++;
      $display("FAIL reset_ctrl: got plot/wr/busy/done/track=%b want 00001",
               {vga_plot, cell_wr, busy, clear_done, enable_tracking});
    end
    vectors++;
    if ({vga_x, vga_y, cell_addr, cell_data, vga_colour} !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_data: got x=%0d y=%0d addr=%0d data=%b c=%0d want all 0",
               vga_x, vga_y, cell_addr, cell_data, vga_colour);
    end
    @(negedge clock);
    reset = 1'b0;
    clr_mon();
    @(negedge clock);
  endtask

  task automatic test_first_paint();
    logic [8:0] ex, ey;
    @(negedge clock);
    x_pos = 9'd16; y_pos = 9'd4; left_click = 1'b1;
    @(negedge clock);
    vectors++;
    if ({cell_wr, vga_plot, cell_addr, cell_data, busy} !== {1'b1, 1'b0, 10'd0, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL first_cell_wr: got wr=%b plot=%b addr=%0d data=%b busy=%b want 1 0 0 1 1",
               cell_wr, vga_plot, cell_addr, cell_data, busy);
    end
    left_click = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      ex = 9'(16 + i % 4);
      ey = 9'(4 + i / 4);
      vectors++;
      if ({vga_plot, cell_wr, vga_x, vga_y, vga_colour} !== {1'b1, 1'b0, ex, ey, 3'd7}) begin
        miscompares++;
        $display("FAIL first_px%0d: got plot=%b wr=%b x=%0d y=%0d c=%0d want 1 0 %0d %0d 7",
                 i, vga_plot, cell_wr, vga_x, vga_y, vga_colour, ex, ey);
      end
    end
    @(negedge clock);
    vectors++;
    if ({busy, vga_plot, cell_wr} !== 3'b000) begin
      miscompares++;
      $display("FAIL first_idle: got busy/plot/wr=%b want 000", {busy, vga_plot, cell_wr});
    end
  endtask

  task automatic test_hold_click();
    clr_mon();
    @(negedge clock);
    x_pos = 9'd50; y_pos = 9'd30; left_click = 1'b1;
    wait_cycles(60);
    vectors++;
    if (wr_cnt !== 1 || last_addr !== 10'd176 || plot_cnt !== 16) begin
      miscompares++;
      $display("FAIL hold_once: got wr=%0d addr=%0d plots=%0d want 1 176 16", wr_cnt, last_addr, plot_cnt);
    end
    x_pos = 9'd54;
    wait_cycles(40);
    vectors++;
    if (wr_cnt !== 2 || last_addr !== 10'd177 || last_data !== 1'b1 || plot_cnt !== 32) begin
      miscompares++;
      $display("FAIL hold_move: got wr=%0d addr=%0d data=%b plots=%0d want 2 177 1 32",
               wr_cnt, last_addr, last_data, plot_cnt);
    end
    left_click = 1'b0;
  endtask

  task automatic test_both_buttons();
    clr_mon();
    @(negedge clock);
    x_pos = 9'd20; y_pos = 9'd10; left_click = 1'b1; right_click = 1'b1;
    wait_cycles(30);
    vectors++;
    if (wr_cnt !== 1 || last_addr !== 10'd29 || last_data !== 1'b1 || nonbg_cnt !== 16) begin
      miscompares++;
      $display("FAIL both_left_wins: got wr=%0d addr=%0d data=%b inkplots=%0d want 1 29 1 16",
               wr_cnt, last_addr, last_data, nonbg_cnt);
    end
    left_click = 1'b0;
    wait_cycles(30);
    vectors++;
    if (wr_cnt !== 2 || last_addr !== 10'd29 || last_data !== 1'b0 || nonbg_cnt !== 16 || plot_cnt !== 32) begin
      miscompares++;
      $display("FAIL right_erase: got wr=%0d addr=%0d data=%b inkplots=%0d plots=%0d want 2 29 0 16 32",
               wr_cnt, last_addr, last_data, nonbg_cnt, plot_cnt);
    end
    right_click = 1'b0;
  endtask

  task automatic test_outside();
    logic [8:0] ox[4];
    logic [8:0] oy[4];
    ox = '{9'd128, 9'd60, 9'd15, 9'd60};
    oy = '{9'd50, 9'd3, 9'd50, 9'd116};
    clr_mon();
    @(negedge clock);
    left_click = 1'b1;
    for (int i = 0; i < 4; i++) begin
      x_pos = ox[i]; y_pos = oy[i];
      wait_cycles(20);
      vectors++;
      if (busy !== 1'b0 || wr_cnt !== 0 || plot_cnt !== 0) begin
        miscompares++;
        $display("FAIL outside_%0d_%0d: got busy=%b wr=%0d plots=%0d want 0 0 0",
                 ox[i], oy[i], busy, wr_cnt, plot_cnt);
      end
    end
    x_pos = 9'd127; y_pos = 9'd115;
    wait_cycles(25);
    vectors++;
    if (wr_cnt !== 1 || last_addr !== 10'd783 || plot_cnt !== 16) begin
      miscompares++;
      $display("FAIL corner_cell: got wr=%0d addr=%0d plots=%0d want 1 783 16", wr_cnt, last_addr, plot_cnt);
    end
    left_click = 1'b0;
  endtask

  task automatic test_clear_during_paint();
    int off_n, done_n;
    logic track_at_done;
    off_n = -1; done_n = -1; track_at_done = 1'b0;
    clr_mon();
    @(negedge clock);
    x_pos = 9'd16; y_pos = 9'd4; left_click = 1'b1;
    @(negedge clock);
    clear_req = 1'b1; left_click = 1'b0;
    vectors++;
    if (enable_tracking !== 1'b1 || cell_wr !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_paint_start: got track=%b wr=%b want 1 1", enable_tracking, cell_wr);
    end
    for (int n = 1; n <= 15000; n++) begin
      @(negedge clock);
      clear_req = 1'b0;
      if (off_n < 0 && !enable_tracking) off_n = n;
      if (clear_done) begin
        done_n = n;
        track_at_done = enable_tracking;
        break;
      end
    end
    #1;
    vectors++;
    if (off_n !== 18) begin
      miscompares++;
      $display("FAIL clr_track_off: got cycle %0d want 18", off_n);
    end
    vectors++;
    if (done_n !== 14130) begin
      miscompares++;
      $display("FAIL clr_done_time: got cycle %0d want 14130 (-1 = timeout)", done_n);
    end
    vectors++;
    if (track_at_done !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_track_on: got %b want 1", track_at_done);
    end
    exp_q.delete();
    exp_q.push_back(10'd0);
    for (int a = 0; a < 784; a++) exp_q.push_back(10'(a));
    vectors++;
    if (got_q.size() !== exp_q.size()) begin
      miscompares++;
      $display("FAIL clr_wr_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL clr_addr%0d: got %0d want %0d", i, got_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (plot_cnt !== 12560 || nonbg_cnt !== 16 || data1_cnt !== 1 || both_cnt !== 0 || done_cnt !== 1) begin
      miscompares++;
      $display("FAIL clr_totals: got plots=%0d inkplots=%0d data1=%0d both=%0d done=%0d want 12560 16 1 0 1",
               plot_cnt, nonbg_cnt, data1_cnt, both_cnt, done_cnt);
    end
    @(negedge clock);
    vectors++;
    if ({busy, clear_done, enable_tracking} !== 3'b001) begin
      miscompares++;
      $display("FAIL clr_after: got busy/done/track=%b want 001", {busy, clear_done, enable_tracking});
    end
  endtask

  task automatic test_reset_mid_clear();
    logic found;
    found = 1'b0;
    clr_mon();
    @(negedge clock);
    clear_req = 1'b1;
    @(negedge clock);
    clear_req = 1'b0;
    for (int n = 0; n < 8000; n++) begin
      @(negedge clock);
      if (cell_wr && cell_addr == 10'd300) begin
        found = 1'b1;
        break;
      end
    end
    vectors++;
    if (found !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_reach300: got %b want 1", found);
    end
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({vga_plot, cell_wr, enable_tracking, busy, clear_done} !== 5'b00100) begin
      miscompares++;
      $display("FAIL rst_abort: got plot/wr/track/busy/done=%b want 00100",
               {vga_plot, cell_wr, enable_tracking, busy, clear_done});
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    clr_mon();
    wait_cycles(30);
    vectors++;
    if (done_cnt !== 0 || wr_cnt !== 0 || plot_cnt !== 0) begin
      miscompares++;
      $display("FAIL rst_quiet: got done=%0d wr=%0d plots=%0d want 0 0 0", done_cnt, wr_cnt, plot_cnt);
    end
    x_pos = 9'd24; y_pos = 9'd8; left_click = 1'b1;
    wait_cycles(25);
    vectors++;
    if (wr_cnt !== 1 || last_addr !== 10'd30 || last_data !== 1'b1 || plot_cnt !== 16 || done_cnt !== 0) begin
      miscompares++;
      $display("FAIL rst_then_paint: got wr=%0d addr=%0d data=%b plots=%0d done=%0d want 1 30 1 16 0",
               wr_cnt, last_addr, last_data, plot_cnt, done_cnt);
    end
    left_click = 1'b0;
  endtask

  initial begin
    clr_mon();
    test_reset();
    test_first_paint();
    test_hold_click();
    test_both_buttons();
    test_outside();
    test_clear_during_paint();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
